// File: rtl/logic_op_sequencer_if.sv
// logic_op_sequencer_if: command, logic-unit and response signals of the sequencer
interface logic_op_sequencer_if #(parameter int WIDTH = 32);
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_op;
  logic cmd_acc;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [WIDTH-1:0] lu_a;
  logic [WIDTH-1:0] lu_b;
  logic [1:0] lu_sel;
  logic [WIDTH-1:0] lu_r;
  logic rsp_valid;
  logic rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic rsp_zero;
  logic rsp_parity;
  logic rsp_illegal;
  logic [15:0] op_count;
  modport master (
    output cmd_valid, cmd_op, cmd_acc, cmd_a, cmd_b, lu_r, rsp_ready,
    input cmd_ready, lu_a, lu_b, lu_sel, rsp_valid, rsp_data, rsp_zero, rsp_parity, rsp_illegal, op_count
  );
  modport slave (
    input cmd_valid, cmd_op, cmd_acc, cmd_a, cmd_b, lu_r, rsp_ready,
    output cmd_ready, lu_a, lu_b, lu_sel, rsp_valid, rsp_data, rsp_zero, rsp_parity, rsp_illegal, op_count
  );
endinterface

// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer: sequences AND/OR/XOR commands through an external logic unit with an accumulator
module logic_op_sequencer #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  logic_op_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] acc, cap;
  logic illegal;
  always_ff @(posedge clk) state <= !rst_n ? IDLE : nxt;
  always_comb begin
    nxt = state == IDLE  ? (bus.cmd_valid ? ISSUE : IDLE) :
          state == ISSUE ? RESP :
          (bus.rsp_ready ? IDLE : RESP);
  end
  always_comb begin
    bus.cmd_ready = rst_n && state == IDLE;
    bus.rsp_valid = state == RESP;
  end
  // illegal op yields a forced-zero result regardless of what the logic unit returns
  assign illegal = bus.lu_sel == 2'b11;
  assign cap = illegal ? '0 : bus.lu_r;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      bus.lu_a <= '0;
      bus.lu_b <= '0;
      bus.lu_sel <= 2'b00;
      bus.rsp_data <= '0;
      bus.rsp_zero <= 1'b0;
      bus.rsp_parity <= 1'b0;
      bus.rsp_illegal <= 1'b0;
      bus.op_count <= '0;
    end else begin
      if (bus.cmd_ready && bus.cmd_valid) begin
        bus.lu_sel <= bus.cmd_op;
        bus.lu_a <= bus.cmd_acc ? acc : bus.cmd_a;
        bus.lu_b <= bus.cmd_b;
      end
      if (state == ISSUE) begin
        bus.rsp_data <= cap;
        bus.rsp_zero <= ~|cap;
        bus.rsp_parity <= ^cap;
        bus.rsp_illegal <= illegal;
        if (!illegal) acc <= bus.lu_r;
      end
      if (state == RESP && bus.rsp_ready) bus.op_count <= bus.op_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_logic_op_sequencer.sv
// tb_logic_op_sequencer: directed scoreboard bench with a behavioural logic unit
module tb_logic_op_sequencer;
  localparam int W = 32;
  localparam int P = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #(P/2) clk = ~clk;
  logic_op_sequencer_if #(.WIDTH(W)) bus();
  logic_op_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.lu_r = bus.lu_sel == 2'b00 ? (bus.lu_a & bus.lu_b) :
                    bus.lu_sel == 2'b01 ? (bus.lu_a | bus.lu_b) :
                    bus.lu_sel == 2'b10 ? (bus.lu_a ^ bus.lu_b) : '0;
  typedef struct {
    logic [W-1:0] d;
    logic il;
    longint t;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int fails = 0;
  logic pv = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && !pv) begin
      if (q.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_data", bus.rsp_data, e.d);
        chk("rsp_zero", bus.rsp_zero, e.d == '0);
        chk("rsp_parity", bus.rsp_parity, ^e.d);
        chk("rsp_illegal", bus.rsp_illegal, e.il);
        chk("rsp_latency", $time, e.t);
      end
    end
    pv <= bus.rsp_valid;
  end
  task automatic send(input logic [1:0] op, input logic acc, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] d, input logic push);
    int n;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_acc = acc;
    bus.cmd_a = a;
    bus.cmd_b = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 20);
    if (!bus.cmd_ready) chk("cmd_ready_timeout", 0, 1);
    if (push) q.push_back('{d, op == 2'b11, $time + 2 * P});
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask
  task automatic idle_wait();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 20);
    if (!bus.cmd_ready) chk("idle_timeout", 0, 1);
  endtask
  task automatic reset_state_chk();
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_flags", {bus.rsp_zero, bus.rsp_parity, bus.rsp_illegal}, 0);
    chk("rst_lu_a", bus.lu_a, 0);
    chk("rst_lu_b", bus.lu_b, 0);
    chk("rst_lu_sel", bus.lu_sel, 0);
    chk("rst_op_count", bus.op_count, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_acc = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_state_chk();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    send(2'b00, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b1);
    idle_wait();
    chk("op_count_1", bus.op_count, 1);
    send(2'b01, 1'b0, 32'h0000_00FF, 32'h0000_0F00, 32'h0000_0FFF, 1'b1);
    send(2'b10, 1'b1, 32'hDEAD_BEEF, 32'h0000_0FFF, 32'h0000_0000, 1'b1);
    send(2'b01, 1'b0, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b1);
    send(2'b11, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    chk("illegal_lu_sel", bus.lu_sel, 2'b11);
    chk("illegal_lu_a", bus.lu_a, 32'hFFFF_FFFF);
    send(2'b01, 1'b1, 32'h0, 32'h0000_0001, 32'h1234_5679, 1'b1);
    idle_wait();
    chk("op_count_6", bus.op_count, 6);
    bus.rsp_ready = 1'b0;
    send(2'b10, 1'b0, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", bus.rsp_valid, 1);
      chk("stall_rsp_data", bus.rsp_data, 32'hAAAA_AAAA);
      chk("stall_cmd_ready", bus.cmd_ready, 0);
      chk("stall_op_count", bus.op_count, 6);
      bus.cmd_valid = i % 2 == 0;
      bus.cmd_op = 2'b01;
      bus.cmd_acc = 1'b0;
      bus.cmd_a = 32'h5555_0000 + i;
      bus.cmd_b = 32'h0000_1111;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    idle_wait();
    chk("op_count_7", bus.op_count, 7);
    send(2'b00, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 1'b1);
    send(2'b01, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_state_chk();
    repeat (3) @(negedge clk);
    chk("abort_no_rsp", bus.rsp_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(2'b01, 1'b1, 32'hFFFF_0000, 32'h0000_0003, 32'h0000_0003, 1'b1);
    idle_wait();
    chk("op_count_after_abort", bus.op_count, 1);
    force bus.op_count = 16'hFFFE;
    #1 release bus.op_count;
    @(negedge clk);
    chk("op_count_preset", bus.op_count, 16'hFFFE);
    send(2'b10, 1'b0, 32'h8000_0001, 32'h0000_0001, 32'h8000_0000, 1'b1);
    idle_wait();
    chk("op_count_ffff", bus.op_count, 16'hFFFF);
    send(2'b00, 1'b0, 32'h0F0F_0F0F, 32'h0000_0007, 32'h0000_0007, 1'b1);
    idle_wait();
    chk("op_count_wrap", bus.op_count, 16'h0000);
    repeat (4) @(negedge clk);
    chk("pending_rsp", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
